// File: rtl/dmem_ctrl.sv
// Two-port arbitrated controller for a word-wide single-port dmem; sub-word stores are read-modify-write.
// Define DMEM_CTRL_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_ctrl #(
  parameter int  DATA_WIDTH    = 32,
  parameter int  DMEM_SZ_IN_KB = 1,
  localparam int ADDR_WIDTH    = $clog2(DMEM_SZ_IN_KB * 1024)
) (
  input  logic                             clk,
  input  logic                             arst,
  input  logic [1:0]                       req_valid,
  output logic [1:0]                       req_ready,
  input  logic [1:0]                       req_we,
  input  logic [1:0][1:0]                  req_size,
  input  logic [1:0][ADDR_WIDTH-1:0]       req_addr,
  input  logic [1:0][DATA_WIDTH-1:0]       req_wdata,
  output logic [1:0]                       rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             mem_write_en,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [DATA_WIDTH-1:0]            mem_rdata
);
  localparam int NUM_LANES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, EXEC, WRITE, RESP} state_t;
  typedef struct packed {
    logic                  we;
    logic [1:0]            size;
    logic [1:0]            off;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t                state;
  req_t                  r, in_req;
  logic                  r_id, sel, accept, in_bad;
  logic [1:0]            grant;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [NUM_LANES-1:0]  lane_mask;
  logic [DATA_WIDTH-1:0] wsh, merged, rsh, ld_data;

`ifdef DMEM_CTRL_RR_EN
  logic last_gnt;
  always_ff @(posedge clk or posedge arst)
    if (arst)        last_gnt <= 1'b0;
    else if (accept) last_gnt <= sel;
`endif

  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) begin
`ifdef DMEM_CTRL_RR_EN
      grant = last_gnt ? 2'b01 : 2'b10;
`else
      grant = 2'b01;
`endif
    end
  end

  assign req_ready = (state == IDLE) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign sel       = grant[1];
  assign in_addr   = req_addr[sel];

  always_comb begin
    in_req.we    = req_we[sel];
    in_req.size  = req_size[sel];
    in_req.off   = in_addr[1:0];
    in_req.wdata = req_wdata[sel];
    case (in_req.size)
      2'b00:   in_bad = 1'b0;
      2'b01:   in_bad = in_addr[0];
      2'b10:   in_bad = |in_addr[1:0];
      default: in_bad = 1'b1;
    endcase
  end

  // Sub-word store merge: shift store data onto its lanes, keep the rest of the read word.
  assign lane_mask = (r.size == 2'b00) ? (NUM_LANES'(1) << r.off) : (NUM_LANES'(3) << r.off);
  assign wsh       = r.wdata << {r.off, 3'b000};
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign merged[8*i +: 8] = lane_mask[i] ? wsh[8*i +: 8] : mem_rdata[8*i +: 8];
  end

  assign rsh = mem_rdata >> {r.off, 3'b000};
  always_comb begin
    case (r.size)
      2'b00:   ld_data = rsh & DATA_WIDTH'(32'h0000_00ff);
      2'b01:   ld_data = rsh & DATA_WIDTH'(32'h0000_ffff);
      default: ld_data = rsh;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state        <= IDLE;
      r            <= '0;
      r_id         <= 1'b0;
      rsp_valid    <= 2'b00;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      mem_write_en <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      mem_write_en <= 1'b0;
      rsp_valid    <= 2'b00;
      case (state)
        IDLE: if (accept) begin
          r        <= in_req;
          r_id     <= sel;
          mem_addr <= {in_addr[ADDR_WIDTH-1:2], 2'b00};
          if (in_bad) begin
            state     <= RESP;
            rsp_valid <= {sel, ~sel};
            rsp_err   <= 1'b1;
          end else begin
            state <= EXEC;
            // Word stores need no read, so the write is issued during EXEC itself.
            if (in_req.we && in_req.size == 2'b10) begin
              mem_write_en <= 1'b1;
              mem_wdata    <= in_req.wdata;
            end
          end
        end
        EXEC: begin
          if (r.we && r.size != 2'b10) begin
            state        <= WRITE;
            mem_write_en <= 1'b1;
            mem_wdata    <= merged;
          end else begin
            state     <= RESP;
            rsp_valid <= {r_id, ~r_id};
            rsp_rdata <= r.we ? '0 : ld_data;
          end
        end
        WRITE: begin
          state     <= RESP;
          rsp_valid <= {r_id, ~r_id};
        end
        default: begin
          state     <= IDLE;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: transaction-level reference model with per-cycle compare, directed cases plus random traffic.
module tb_dmem_ctrl;
  localparam int AW = 10;
  localparam int NW = 256;

  logic             clk = 1'b0;
  logic             arst;
  logic [1:0]       req_valid, req_ready, req_we, rsp_valid;
  logic [1:0][1:0]  req_size;
  logic [1:0][AW-1:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [31:0]      rsp_rdata, mem_wdata, mem_rdata;
  logic             rsp_err, mem_write_en;
  logic [AW-1:0]    mem_addr;

  logic [31:0] dmem    [NW];
  logic [31:0] ref_mem [NW];

  int n_chk = 0, n_fail = 0, cyc = 0;
  logic chk_en = 1'b0;
  int acc_cnt [2];
  int seen    [2];
  int gnt_q   [$];
  logic [31:0] last_rdata [2];
  logic        last_err   [2];

  // model state
  int busy_until, rsp_cyc, wr_cyc;
  logic rr_last;
  logic [1:0] exp_rdy, exp_rsp_v;
  logic [31:0] exp_rdata, exp_wdata;
  logic exp_err;
  int exp_waddr;

  dmem_ctrl dut (
    .clk(clk), .arst(arst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'h5a5a_0000;
  endfunction

  assign mem_rdata = dmem[mem_addr[AW-1:2]];

  initial begin
    for (int i = 0; i < NW; i++) dmem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_write_en) dmem[mem_addr[AW-1:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic model_accept(input int p);
    int a, s, nb, w, off, n;
    logic bad, we;
    logic [31:0] wd, nw;
    a = int'(req_addr[p]); s = int'(req_size[p]); we = req_we[p]; wd = req_wdata[p];
    n = cyc; nb = 1 << s; w = a / 4; off = a % 4;
    bad = (s == 3) || (a % nb != 0);
    acc_cnt[p]++;
    gnt_q.push_back(p);
    rr_last   = (p == 1);
    exp_rsp_v = (p == 1) ? 2'b10 : 2'b01;
    exp_rdata = 32'h0;
    exp_err   = 1'b0;
    if (bad) begin
      exp_err = 1'b1;
      rsp_cyc = n + 1;
    end else if (!we) begin
      for (int b = 0; b < nb; b++) exp_rdata[8*b +: 8] = ref_mem[w][8*(off+b) +: 8];
      rsp_cyc = n + 2;
    end else begin
      nw = ref_mem[w];
      for (int b = 0; b < nb; b++) nw[8*(off+b) +: 8] = wd[8*b +: 8];
      ref_mem[w] = nw;
      exp_wdata  = nw;
      exp_waddr  = w * 4;
      wr_cyc     = (nb == 4) ? n + 1 : n + 2;
      rsp_cyc    = wr_cyc + 1;
    end
    busy_until = rsp_cyc + 1;
  endtask

  // compare process: checks DUT outputs against the model every cycle
  initial begin
    for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
    acc_cnt[0] = 0; acc_cnt[1] = 0;
    busy_until = 0; rsp_cyc = -1; wr_cyc = -1; rr_last = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (arst) begin
        busy_until = 0; rsp_cyc = -1; wr_cyc = -1; rr_last = 1'b0;
      end else if (chk_en) begin
        exp_rdy = 2'b00;
        if (cyc >= busy_until && req_valid != 2'b00) begin
          if (req_valid == 2'b11) begin
`ifdef DMEM_CTRL_RR_EN
            exp_rdy = rr_last ? 2'b01 : 2'b10;
`else
            exp_rdy = 2'b01;
`endif
          end else exp_rdy = req_valid;
        end
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), (cyc == rsp_cyc) ? 32'(exp_rsp_v) : 32'h0);
        if (cyc == rsp_cyc) begin
          chk("rsp_rdata", rsp_rdata, exp_rdata);
          chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        end
        for (int p = 0; p < 2; p++)
          if (rsp_valid[p]) begin last_rdata[p] = rsp_rdata; last_err[p] = rsp_err; end
        chk("mem_write_en", 32'(mem_write_en), 32'(cyc == wr_cyc));
        if (cyc == wr_cyc) begin
          chk("mem_addr", 32'(mem_addr), 32'(exp_waddr));
          chk("mem_wdata", mem_wdata, exp_wdata);
        end
        if (exp_rdy != 2'b00) model_accept(exp_rdy[1] ? 1 : 0);
      end
    end
  end

  task automatic do_req(input int p, input logic we, input logic [1:0] s,
                        input logic [AW-1:0] a, input logic [31:0] wd);
    bit done;
    done = 1'b0;
    @(negedge clk);
    req_valid[p] = 1'b1; req_we[p] = we; req_size[p] = s; req_addr[p] = a; req_wdata[p] = wd;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (acc_cnt[p] != seen[p]) begin seen[p] = acc_cnt[p]; done = 1'b1; end
    end
    req_valid[p] = 1'b0;
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: port %0d not accepted within 50 cycles", p);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic rand_req(input int p);
    int s, a;
    s = ($urandom % 10 == 0) ? 3 : int'($urandom_range(0, 2));
    a = ($urandom % 4 == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 127));
    if ($urandom % 8 != 0 && s != 3) a = a & ~((1 << s) - 1);
    req_we[p] = 1'($urandom % 2); req_size[p] = 2'(s); req_addr[p] = AW'(a);
    req_wdata[p] = $urandom; req_valid[p] = 1'b1;
  endtask

  initial begin
    int rem [2];
    int exp_g [8];
    seen[0] = 0; seen[1] = 0;
    arst = 1'b1; req_valid = '0; req_we = '0; req_size = '0; req_addr = '0; req_wdata = '0;
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_mem_we", 32'(mem_write_en), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk); arst = 1'b0;
    @(negedge clk); chk_en = 1'b1;

    do_req(0, 1'b1, 2'd2, 10'h010, 32'hDEADBEEF);
    chk("word_store_mem", dmem[4], 32'hDEADBEEF);
    do_req(0, 1'b0, 2'd2, 10'h010, 32'h0);
    chk("word_load_data", last_rdata[0], 32'hDEADBEEF);
    chk("word_load_err", 32'(last_err[0]), 32'h0);
    do_req(0, 1'b1, 2'd2, 10'h010, 32'h11223344);
    do_req(0, 1'b1, 2'd0, 10'h012, 32'h000000AA);
    chk("byte_store_mem", dmem[4], 32'h11AA3344);
    do_req(1, 1'b0, 2'd0, 10'h012, 32'h0);
    chk("byte_load_p1", last_rdata[1], 32'h000000AA);
    do_req(1, 1'b0, 2'd1, 10'h011, 32'h0);
    chk("misalign_err", 32'(last_err[1]), 32'h1);
    chk("misalign_rdata", last_rdata[1], 32'h0);
    do_req(0, 1'b1, 2'd3, 10'h014, 32'h12345678);
    chk("size11_err", 32'(last_err[0]), 32'h1);
    chk("size11_nowrite", dmem[5], init_word(5));
    do_req(0, 1'b1, 2'd2, 10'h020, 32'hCAFEF00D);

    // both ports continuously valid, 4 word loads each
    gnt_q.delete(); rem[0] = 4; rem[1] = 4;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      req_valid[p] = 1'b1; req_we[p] = 1'b0; req_size[p] = 2'd2; req_addr[p] = AW'(32'h40 + 16 * p);
    end
    for (int i = 0; i < 200 && (rem[0] + rem[1]) > 0; i++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++)
        if (acc_cnt[p] != seen[p]) begin
          seen[p] = acc_cnt[p]; rem[p]--;
          if (rem[p] == 0) req_valid[p] = 1'b0;
          else req_addr[p] = AW'(32'h40 + 16 * p + 4 * rem[p]);
        end
    end
    req_valid = '0;
    repeat (4) @(negedge clk);
`ifdef DMEM_CTRL_RR_EN
    exp_g = '{1, 0, 1, 0, 1, 0, 1, 0};
`else
    exp_g = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
    chk("arb_count", 32'(gnt_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < gnt_q.size(); i++) chk("arb_order", 32'(gnt_q[i]), 32'(exp_g[i]));

    // reset during WRITE of a half store
    @(negedge clk); chk_en = 1'b0;
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_size[0] = 2'd1; req_addr[0] = 10'h022; req_wdata[0] = 32'h5555;
    #1 chk("arst_accept", 32'(req_ready), 32'h1);
    @(negedge clk); req_valid[0] = 1'b0;
    @(negedge clk); #1;
    chk("arst_write_pending", 32'(mem_write_en), 32'h1);
    chk("arst_merge", mem_wdata, 32'h5555F00D);
    arst = 1'b1; #1;
    chk("arst_we", 32'(mem_write_en), 32'h0);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("arst_mem_addr", 32'(mem_addr), 32'h0);
    chk("arst_mem_wdata", mem_wdata, 32'h0);
    chk("arst_rsp_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    chk("arst_mem_kept", dmem[8], 32'hCAFEF00D);
    chk("arst_no_rsp", 32'(rsp_valid), 32'h0);
    arst = 1'b0;
    @(negedge clk); chk_en = 1'b1;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (acc_cnt[p] != seen[p]) begin seen[p] = acc_cnt[p]; req_valid[p] = 1'b0; end
        else if (!req_valid[p] && $urandom % 3 == 0) rand_req(p);
      end
    end
    @(negedge clk);
    for (int p = 0; p < 2; p++) if (acc_cnt[p] != seen[p]) seen[p] = acc_cnt[p];
    req_valid = '0;
    repeat (10) @(negedge clk);
    chk_en = 1'b0;
    for (int i = 0; i < NW; i++) chk("final_mem", dmem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data memory controller sitting between two load/store requesters (port 0: core LSU, port 1: debug/DMA) and the single-port, word-wide `dmem`. It arbitrates the two ports, serialises one transaction at a time, performs byte/halfword stores as read-modify-write on the word memory, returns right-aligned load data, and flags misaligned or illegal-size accesses without touching memory.

## Interface
- `DATA_WIDTH`, 32, memory word width; only 32 supported (4 byte lanes).
- `DMEM_SZ_IN_KB`, 1, memory size; `ADDR_WIDTH` = clog2(DMEM_SZ_IN_KB*1024) is a localparam (byte address).

- `clk`  in  1  clock; one clock, all state on rising edge.
- `arst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  [1:0]  per-port request valid.
- `req_ready`  out  [1:0]  per-port accept; at most one bit set.
- `req_we`  in  [1:0]  per-port 1 = store, 0 = load.
- `req_size`  in  [1:0][1:0]  per-port size: 00 byte, 01 half, 10 word, 11 illegal.
- `req_addr`  in  [1:0][ADDR_WIDTH-1:0]  per-port byte address.
- `req_wdata`  in  [1:0][31:0]  per-port store data, right-aligned.
- `rsp_valid`  out  [1:0]  one-cycle response pulse to the granted port.
- `rsp_rdata`  out  32  load data, right-aligned, zero-extended; 0 for stores/errors.
- `rsp_err`  out  1  qualified by `rsp_valid`: misaligned or illegal size.
- `mem_write_en`  out  1  to dmem `write_en`.
- `mem_addr`  out  ADDR_WIDTH  to dmem `addr`; always {addr[ADDR_WIDTH-1:2], 2'b00}.
- `mem_wdata`  out  32  to dmem `data_in`.
- `mem_rdata`  in  32  from dmem `data_out` (combinational read).

## Operation
- States: IDLE, EXEC, WRITE, RESP.
- IDLE: if any `req_valid`, arbitrate, assert `req_ready` of the winner combinationally; on the accept edge latch port id, we, size, addr, wdata. Check alignment: half needs addr[0]=0, word needs addr[1:0]=0, size 11 always illegal. Illegal -> RESP with err; else -> EXEC.
- EXEC, load: capture `mem_rdata` shifted right by 8*addr[1:0] (half: addr[1]) and masked to size -> RESP.
- EXEC, word store: `mem_write_en`=1, `mem_wdata`=wdata -> RESP.
- EXEC, byte/half store: capture `mem_rdata` into merge register, replace addressed lane(s) with wdata low bits -> WRITE.
- WRITE: `mem_write_en`=1, `mem_wdata`=merged word -> RESP.
- RESP: `rsp_valid[id]`=1 for exactly one cycle, `rsp_rdata`, `rsp_err` valid -> IDLE. Requesters cannot stall the response.
- `req_ready` low in all states except IDLE; one outstanding transaction total.
- `mem_write_en` never asserted outside EXEC/WRITE or for erroring requests.
- Out-of-range address bits above ADDR_WIDTH do not exist; addresses wrap within memory.

## Timing
- Reset: state IDLE, `req_ready`=0 (combinational, follows `req_valid` after reset release), `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `mem_write_en`=0, `mem_addr`=0, `mem_wdata`=0, arbitration pointer = port 0 last granted.
- Accept at edge T: load / word store rsp at T+2; sub-word store rsp at T+3 (write in cycle T+2); error rsp at T+1.
- Store is committed at the edge ending EXEC/WRITE, before `rsp_valid`.
- Back-to-back: next accept earliest the cycle after RESP (load: one every 3 cycles).
- Simultaneous `req_valid` on both ports: see Configuration; loser's `req_ready` stays 0 and its request must be held stable.
- `arst` mid-transaction: return to IDLE immediately, no pending write issued, no response delivered; completed writes persist.

## Configuration
- `DMEM_CTRL_RR_EN` defined: round-robin; when both valid, grant the port not granted last; pointer updates on each accept.
- Undefined: fixed priority, port 0 always wins; port 1 served only when port 0 idle in IDLE.

## Test plan
- Word store port 0 addr 0x010 data 0xDEADBEEF, then load word 0x010 -> write at T+1, rsp at T+2; load returns 0xDEADBEEF, err 0.
- Byte store 0xAA to 0x012 over word 0x11223344 -> mem write 0x11AA3344 at T+2, rsp at T+3; byte load 0x012 returns 0x000000AA.
- Half load at 0x011 or size 11 -> `rsp_err`=1 at T+1, `rsp_rdata`=0, no `mem_write_en` pulse.
- Both ports valid continuously, 4 loads each -> with `DMEM_CTRL_RR_EN` grants alternate 1,0,1,0…; without it port 0 gets all 4 first.
- `arst` high during WRITE of a half store -> no write, memory word unchanged, outputs at reset values, no `rsp_valid`.
- Load immediately after sub-word store from other port -> returns merged data.
